seq_scan_ctrl: RTL and testbench

//  Sequences a serial pattern matcher over parallel data words. A word is accepted over a

---
 rtl/seq_scan_ctrl_pkg.sv | 18 +
 rtl/seq_scan_ctrl_if.sv | 32 +++
 rtl/seq_scan_ctrl_match.sv | 44 ++++
 rtl/seq_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seq_scan_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and constants for the serial pattern scan controller.
// Holds the FSM state encoding and the default detector pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [3:0] PAT_1011 = 4'b1011;

  // Width helper that never returns zero, so 1-entry ranges still get a bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-side bus of the scan controller: config, input handshake and results.
// Handshake: a word transfers on the rising CLK edge where IN_VALID && IN_READY.
interface seq_scan_ctrl_if #(
  parameter int WORD_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5
);
  import seq_pkg::*;

  logic              CFG_WE;
  logic [PAT_W-1:0]  CFG_PAT;
  logic              CFG_OVL;
  logic              IN_VALID;
  logic              IN_READY;
  logic [WORD_W-1:0] IN_DATA;
  logic              BUSY;
  logic              HIT;
  logic              DONE;
  logic [CNT_W-1:0]  MATCH_CNT;
  state_t            state;

  modport master (
    output CFG_WE, CFG_PAT, CFG_OVL, IN_VALID, IN_DATA,
    input  IN_READY, BUSY, HIT, DONE, MATCH_CNT, state
  );

  modport slave (
    input  CFG_WE, CFG_PAT, CFG_OVL, IN_VALID, IN_DATA,
    output IN_READY, BUSY, HIT, DONE, MATCH_CNT, state
  );

endinterface

// File: rtl/seq_scan_ctrl_match.sv
// Serial PAT_W-bit detector: shifting window, fill counter and pattern compare.
// The hit is Mealy: it reflects the bit presented in the current cycle.
module seq_match_core #(
  parameter int PAT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             data_bit,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             ovl,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  window_nx;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_inc;

  always_comb begin
    window_nx = {window[PAT_W-2:0], data_bit};
    fill_inc  = (fill == FULL) ? fill : fill + 1'b1;
    hit       = shift_en && (fill_inc == FULL) && (window_nx == pattern);
  end

  // Non-overlapping mode drops the fill on a hit so the next match needs fresh bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      window <= '0;
      fill   <= '0;
    end else if (clr) begin
      window <= '0;
      fill   <= '0;
    end else if (shift_en) begin
      window <= window_nx;
      fill   <= (hit && !ovl) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: accepts a word, shifts it MSB-first through the detector,
// counts matches and reports the count with a one-cycle DONE pulse.
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int               WORD_W  = 16,
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 5,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_1011,
  parameter logic             RST_OVL = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  seq_scan_ctrl_if.slave  bus
);

  localparam int IDX_W = clog2_min1(WORD_W);

  state_t            state;
  state_t            state_nx;
  logic [WORD_W-1:0] shift_reg;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  run_cnt;
  logic [CNT_W-1:0]  run_cnt_nx;
  logic [CNT_W-1:0]  match_cnt;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic              accept;
  logic              shift_en;
  logic              last_bit;
  logic              hit;

  seq_match_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .CLK      (CLK),
    .RST      (RST),
    .data_bit (shift_reg[WORD_W-1]),
    .shift_en (shift_en),
    .clr      (accept),
    .ovl      (ovl_q),
    .pattern  (pat_q),
    .hit      (hit)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    shift_en = 1'b0;
    last_bit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.IN_VALID) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bit_idx == '0) begin
          last_bit = 1'b1;
          state_nx = REPORT;
        end
      end
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    run_cnt_nx = run_cnt;
    if (hit && (run_cnt != {CNT_W{1'b1}})) begin
      run_cnt_nx = run_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Config only moves in IDLE, so a word in flight keeps the settings it was accepted with.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pat_q <= RST_PAT;
      ovl_q <= RST_OVL;
    end else if ((state == IDLE) && bus.CFG_WE) begin
      pat_q <= bus.CFG_PAT;
      ovl_q <= bus.CFG_OVL;
    end
  end

  // MATCH_CNT loads on the last bit so it is already valid while DONE is high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      run_cnt   <= '0;
      match_cnt <= '0;
    end else if (accept) begin
      shift_reg <= bus.IN_DATA;
      bit_idx   <= IDX_W'(WORD_W - 1);
      run_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
      bit_idx   <= bit_idx - 1'b1;
      run_cnt   <= run_cnt_nx;
      if (last_bit) begin
        match_cnt <= run_cnt_nx;
      end
    end
  end

  assign bus.IN_READY  = (state == IDLE);
  assign bus.BUSY      = (state != IDLE);
  assign bus.DONE      = (state == REPORT);
  assign bus.HIT       = hit;
  assign bus.MATCH_CNT = match_cnt;
  assign bus.state     = state;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed and randomized bench for seq_scan_ctrl against a bit-list reference model.
// A second instance with a 2-bit counter shares the stimulus to observe saturation.
module tb_seq_scan_ctrl;
  import seq_pkg::*;

  localparam int W = 16;
  localparam int P = 4;
  localparam int C = 5;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  seq_scan_ctrl_if #(.WORD_W(W), .PAT_W(P), .CNT_W(C)) bus ();
  seq_scan_ctrl_if #(.WORD_W(W), .PAT_W(P), .CNT_W(2)) bus2 ();

  assign bus2.CFG_WE   = bus.CFG_WE;
  assign bus2.CFG_PAT  = bus.CFG_PAT;
  assign bus2.CFG_OVL  = bus.CFG_OVL;
  assign bus2.IN_VALID = bus.IN_VALID;
  assign bus2.IN_DATA  = bus.IN_DATA;

  seq_scan_ctrl #(.WORD_W(W), .PAT_W(P), .CNT_W(C)) dut (
    .CLK (CLK), .RST (RST), .bus (bus.slave)
  );

  seq_scan_ctrl #(.WORD_W(W), .PAT_W(P), .CNT_W(2)) dut_sat (
    .CLK (CLK), .RST (RST), .bus (bus2.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_acc = -1;
  logic [P-1:0] m_pat;
  logic         m_ovl;
  logic [C-1:0] exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list every window of P consecutive bits in scan order; in
  // non-overlapping mode a window may not reuse bits of the previous match.
  function automatic void model(input logic [W-1:0] w, input logic [P-1:0] p, input logic o,
                                output logic [W-1:0] mask, output int cnt);
    int last_end = -1;
    logic [P-1:0] win;
    mask = '0;
    cnt  = 0;
    for (int k = P - 1; k < W; k++) begin
      win = w[(W + P - 2 - k) -: P];
      if ((win == p) && (o || (k - P + 1 > last_end))) begin
        mask[k] = 1'b1;
        cnt++;
        last_end = k;
      end
    end
  endfunction

  // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  task automatic run_word(input logic [W-1:0] d, input bit cfg_we, input logic [P-1:0] pat,
                          input logic ovl, input bit noisy, input bit chk_gap);
    logic [W-1:0] mask;
    int cnt;
    int sat;
    bus.CFG_WE   = cfg_we;
    bus.CFG_PAT  = pat;
    bus.CFG_OVL  = ovl;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = d;
    if (cfg_we) begin
      m_pat = pat;
      m_ovl = ovl;
    end
    model(d, m_pat, m_ovl, mask, cnt);
    exp_q.push_back(C'(cnt));
    sat = (cnt > 3) ? 3 : cnt;
    @(negedge CLK);
    check("ready_idle", bus.IN_READY, 1);
    check("busy_idle", bus.BUSY, 0);
    check("hit_idle", bus.HIT, 0);
    if (chk_gap && last_acc >= 0) check("accept_gap", cyc - last_acc, W + 2);
    last_acc = cyc;
    @(posedge CLK); #1;
    for (int k = 0; k <= W; k++) begin
      if (noisy) begin
        bus.IN_VALID = 1'($urandom_range(0, 1));
        bus.IN_DATA  = W'($urandom);
        bus.CFG_WE   = 1'($urandom_range(0, 1));
        bus.CFG_PAT  = P'($urandom);
        bus.CFG_OVL  = 1'($urandom_range(0, 1));
      end else begin
        bus.IN_VALID = 1'b0;
        bus.CFG_WE   = 1'b0;
      end
      @(negedge CLK);
      if (k < W) begin
        check($sformatf("hit_b%0d", k + 1), bus.HIT, mask[k]);
        check("busy_shift", bus.BUSY, 1);
        check("ready_shift", bus.IN_READY, 0);
        check("done_shift", bus.DONE, 0);
      end else begin
        check("done_report", bus.DONE, 1);
        check("match_cnt", bus.MATCH_CNT, exp_q.pop_front());
        check("match_cnt_sat", bus2.MATCH_CNT, sat);
        check("hit_report", bus.HIT, 0);
        check("ready_report", bus.IN_READY, 0);
      end
      @(posedge CLK); #1;
    end
    bus.IN_VALID = 1'b0;
    bus.CFG_WE   = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    bus.CFG_WE = 1'b0; bus.CFG_PAT = '0; bus.CFG_OVL = 1'b0;
    bus.IN_VALID = 1'b0; bus.IN_DATA = '0;
    m_pat = 4'b1011; m_ovl = 1'b0;
    @(negedge CLK);
    check("rst_ready", bus.IN_READY, 1);
    check("rst_busy", bus.BUSY, 0);
    check("rst_hit", bus.HIT, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_cnt", bus.MATCH_CNT, 0);
    check("rst_state", bus.state, IDLE);
    @(posedge CLK); #1 RST = 1'b0;

    // Reset defaults on B0B0
    run_word(16'hB0B0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK); check("held_b0b0", bus.MATCH_CNT, 2);
    check("done_low_idle", bus.DONE, 0);
    @(posedge CLK); #1;

    // B600 non-overlap and overlap
    run_word(16'hB600, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
    @(negedge CLK); check("held_b600_nov", bus.MATCH_CNT, 1);
    @(posedge CLK); #1;
    run_word(16'hB600, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
    @(negedge CLK); check("held_b600_ovl", bus.MATCH_CNT, 2);
    @(posedge CLK); #1;

    // All-zero pattern on an all-zero word, plus saturation on the 2-bit instance
    run_word(16'h0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge CLK); check("held_zero_nov", bus.MATCH_CNT, 4);
    @(posedge CLK); #1;
    run_word(16'h0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    @(negedge CLK); check("held_zero_ovl", bus.MATCH_CNT, 13);
    check("held_zero_sat", bus2.MATCH_CNT, 3);
    @(posedge CLK); #1;

    // Config writes during SHIFT are ignored for this and the next word
    run_word(16'hB0B0, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0);
    run_word(16'hB0B0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK); check("held_old_pat", bus.MATCH_CNT, 2);
    @(posedge CLK); #1;

    // Back-to-back with IN_VALID held and noise during busy cycles
    last_acc = -1;
    for (int i = 0; i < 6; i++) begin
      run_word(W'($urandom), 1'($urandom_range(0, 1)), P'($urandom), 1'($urandom_range(0, 1)),
               1'b1, 1'b1);
    end

    // Reset in the middle of a word
    run_word(16'hB0B0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
    bus.IN_VALID = 1'b1; bus.IN_DATA = 16'hFFFF;
    @(posedge CLK); #1 bus.IN_VALID = 1'b0;
    repeat (8) @(posedge CLK);
    #1 RST = 1'b1;
    m_pat = 4'b1011; m_ovl = 1'b0;
    @(negedge CLK);
    check("abort_ready", bus.IN_READY, 1);
    check("abort_busy", bus.BUSY, 0);
    check("abort_cnt", bus.MATCH_CNT, 0);
    check("abort_done", bus.DONE, 0);
    @(posedge CLK); #1 RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); check("abort_no_done", bus.DONE, 0);
    end
    @(posedge CLK); #1;
    run_word(16'hB0B0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Randomized words and configurations
    for (int i = 0; i < 24; i++) begin
      run_word(W'($urandom), 1'($urandom_range(0, 1)), P'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
